seg_shift_ctrl: RTL and testbench

Serialises the 64-bit segment map produced for the board's seven-segment display into the daisy-chained serial shift registers that drive the digits, then latches it. It sits between the segment-mapping logic (parallel 64-bit map) and the display pins. It owns the shift clock, the serial data line and the latch/clear strobes, and runs one complete transfer per `start` request.

---
 rtl/seg_shift_ctrl_pkg.sv | 18 +
 rtl/seg_clk_div.sv | 45 ++++
 rtl/seg_shift_ctrl.sv | 120 ++++++++++++
 tb/tb_seg_shift_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_shift_ctrl_pkg.sv
// Shared definitions for the seven-segment serial shift controller:
// controller state encoding and default geometry of the shift chain.
package seg_shift_ctrl_pkg;

    // Default chain length: one bit per segment output across all digits.
    localparam int unsigned DEF_DATA_W  = 64;

    // Default system cycles per shift-clock half-period.
    localparam int unsigned DEF_CLK_DIV = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seg_clk_div.sv
// Phase timer for the shift controller: while enabled, emits a one-cycle
// phase_end_o tick every CLK_DIV cycles; held at zero while disabled so each
// enabled stretch starts with a full-length phase.
module seg_clk_div
    import seg_shift_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic phase_end_o
);

    localparam int unsigned CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Tick on the last cycle of each phase while enabled.
    assign phase_end_o = en_i && (cnt_q == LAST);

    // Next count: clear when idle, wrap at the end of every phase.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Phase counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_shift_ctrl.sv
// Serialises the parallel segment map into the daisy-chained display shift
// registers (MSB first), then pulses the output latch. One transfer runs per
// accepted start; every pin driven toward the display is a flop output.
module seg_shift_ctrl
    import seg_shift_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] par_data,
    output logic              busy,
    output logic              done,
    output logic              s_clk,
    output logic              s_data,
    output logic              s_latch,
    output logic              s_clrn
);

    localparam int unsigned BW = $clog2(DATA_W) + 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    state_t            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [BW-1:0]     bitcnt_q;
    logic              busy_q;
    logic              done_q;
    logic              sclk_q;
    logic              latch_q;
    logic              clrn_q;

    logic              div_en;
    logic              phase_end;

    // The phase timer runs through both the shift phases and the latch pulse.
    assign div_en = (state_q == SHIFT) || (state_q == LATCH);

    seg_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (div_en),
        .phase_end_o (phase_end)
    );

    // Shift left with zero fill; after the last bit the register is all zero,
    // which keeps the serial line low through LATCH and back in IDLE.
    always_comb begin
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
    end

    // Transfer sequencer: owns state, shift register, bit count and strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sclk_q   <= 1'b0;
            latch_q  <= 1'b0;
            clrn_q   <= 1'b0;
        end else begin
            clrn_q <= 1'b1;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg_q  <= par_data;
                        bitcnt_q <= '0;
                        sclk_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (phase_end) begin
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q   <= 1'b0;
                            shreg_q  <= shreg_d;
                            bitcnt_q <= bitcnt_q + BW'(1);
                            if (bitcnt_q == BIT_LAST) begin
                                latch_q <= 1'b1;
                                state_q <= LATCH;
                            end
                        end
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        latch_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign s_clk   = sclk_q;
    assign s_data  = shreg_q[DATA_W-1];
    assign s_latch = latch_q;
    assign s_clrn  = clrn_q;

endmodule

// File: tb/tb_seg_shift_ctrl.sv
// Bench for seg_shift_ctrl: default-geometry instance plus a CLK_DIV=1 instance.
module tb_seg_shift_ctrl;

    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_start, b_start;
    logic [DW-1:0] a_par, b_par;
    logic a_busy, a_done, a_sclk, a_sdata, a_latch, a_clrn;
    logic b_busy, b_done, b_sclk, b_sdata, b_latch, b_clrn;

    seg_shift_ctrl u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .par_data(a_par),
        .busy(a_busy), .done(a_done), .s_clk(a_sclk), .s_data(a_sdata),
        .s_latch(a_latch), .s_clrn(a_clrn)
    );

    seg_shift_ctrl #(.DATA_W(64), .CLK_DIV(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .par_data(b_par),
        .busy(b_busy), .done(b_done), .s_clk(b_sclk), .s_data(b_sdata),
        .s_latch(b_latch), .s_clrn(b_clrn)
    );

    // Monitor observes whichever instance is selected.
    logic sel = 1'b0;
    logic m_busy, m_done, m_sclk, m_sdata, m_latch;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_sclk  = sel ? b_sclk  : a_sclk;
    assign m_sdata = sel ? b_sdata : a_sdata;
    assign m_latch = sel ? b_latch : a_latch;

    int total = 0;
    int bad   = 0;
    int ncyc = 0, rises = 0, latch_cyc = 0, busy_cyc = 0, idle_cyc = 0, done_cnt = 0;
    int first_rise = -1;
    int last_t0 = 0;
    logic prev_sclk = 1'b0;
    bit bitq[$];
    int doneq[$];

    typedef struct {
        logic [DW-1:0] data;
        int            latch_len;
        int            t;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard consumer: pops expected bits on each s_clk rise and the
    // expected completion cycle on each done pulse.
    task automatic monitor();
        bit e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (m_busy) busy_cyc++; else idle_cyc++;
            if (m_latch) begin
                latch_cyc++;
                chk("s_clk_low_in_latch", m_sclk, 0);
            end
            if (m_sclk && !prev_sclk) begin
                rises++;
                if (first_rise < 0) first_rise = ncyc;
                chk("rise_expected", bitq.size() > 0, 1);
                if (bitq.size() > 0) begin
                    e = bitq.pop_front();
                    chk("s_data_at_rise", m_sdata, e);
                end
            end
            if (m_done) begin
                done_cnt++;
                chk("done_expected", doneq.size() > 0, 1);
                if (doneq.size() > 0) chk("done_cycle", ncyc, doneq.pop_front());
            end
            prev_sclk = m_sclk;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        int n = 0;
        while (ncyc < c && n < 2000) begin
            tick();
            n++;
        end
    endtask

    // Producer: drives start for one sampling edge (or holds it) and pushes
    // the expected serial bits and done cycle.
    task automatic start_xfer(input logic [DW-1:0] d, input int t, input bit hold);
        tick();
        if (sel) begin b_par = d; b_start = 1'b1; end
        else     begin a_par = d; a_start = 1'b1; end
        last_t0 = ncyc;
        first_rise = -1;
        for (int i = DW - 1; i >= 0; i--) bitq.push_back(d[i]);
        doneq.push_back(ncyc + t);
        tick();
        if (!hold) begin a_start = 1'b0; b_start = 1'b0; end
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk("done_reached", done_cnt, target);
    endtask

    task automatic check_xfer(input string tag, input int r0, input int l0, input int b0,
                              input int d0, input int cd, input int t);
        chk({tag, "_rises"}, rises - r0, DW);
        chk({tag, "_latch_len"}, latch_cyc - l0, cd);
        chk({tag, "_busy_len"}, busy_cyc - b0, t);
        chk({tag, "_done_count"}, done_cnt - d0, 1);
        chk({tag, "_first_rise"}, first_rise - last_t0, 1 + cd);
        chk({tag, "_bits_left"}, bitq.size(), 0);
    endtask

    task automatic run_one(input string tag, input logic [DW-1:0] d, input int cd, input int t);
        int r0, l0, b0, d0;
        r0 = rises; l0 = latch_cyc; b0 = busy_cyc; d0 = done_cnt;
        start_xfer(d, t, 1'b0);
        wait_done(d0 + 1, t + 50);
        repeat (2) tick();
        check_xfer(tag, r0, l0, b0, d0, cd, t);
    endtask

    initial begin
        int r0, l0, b0, d0, i1;
        vecs[0] = '{64'h8000_0000_0000_0001, 2, 259};
        vecs[1] = '{64'hA5A5_5A5A_0F0F_F0F0, 2, 259};
        vecs[2] = '{64'h0000_0000_0000_0000, 2, 259};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 2, 259};
        vecs[4] = '{64'h0123_4567_89AB_CDEF, 2, 259};

        a_start = 1'b0; b_start = 1'b0; a_par = '0; b_par = '0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) tick();
        chk("reset_outputs_a", {a_busy, a_done, a_sclk, a_sdata, a_latch, a_clrn}, 0);
        chk("reset_outputs_b", {b_busy, b_done, b_sclk, b_sdata, b_latch, b_clrn}, 0);
        rst = 1'b0;
        chk("clrn_before_edge", a_clrn, 0);
        tick();
        chk("clrn_after_release", a_clrn, 1);
        chk("idle_after_release", {a_busy, a_done, a_sclk, a_latch}, 0);

        // Table-driven transfers on the default instance
        foreach (vecs[k]) run_one($sformatf("vec%0d", k), vecs[k].data, vecs[k].latch_len, vecs[k].t);

        // Capture isolation: par_data cleared at cycle 5
        r0 = rises; l0 = latch_cyc; b0 = busy_cyc; d0 = done_cnt;
        start_xfer(64'hFFFF_0000_FFFF_0000, 259, 1'b0);
        wait_until(last_t0 + 5);
        a_par = '0;
        wait_done(d0 + 1, 320);
        repeat (2) tick();
        check_xfer("capture", r0, l0, b0, d0, 2, 259);

        // Back-to-back with start held high
        r0 = rises; b0 = busy_cyc; d0 = done_cnt;
        start_xfer(64'h1357_9BDF_2468_ACE0, 259, 1'b1);
        for (int i = DW - 1; i >= 0; i--) bitq.push_back(a_par[i]);
        doneq.push_back(last_t0 + 519);
        wait_done(d0 + 1, 320);
        i1 = idle_cyc;
        wait_done(d0 + 2, 320);
        a_start = 1'b0;
        chk("b2b_idle_gap", idle_cyc - i1, 1);
        repeat (3) tick();
        chk("b2b_rises", rises - r0, 2 * DW);
        chk("b2b_busy_len", busy_cyc - b0, 2 * 259);
        chk("b2b_stopped", a_busy, 0);

        // Reset mid-transfer at cycle 100
        l0 = latch_cyc;
        start_xfer(64'hDEAD_BEEF_0000_FFFF, 259, 1'b0);
        wait_until(last_t0 + 100);
        chk("busy_before_reset", a_busy, 1);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {a_busy, a_done, a_sclk, a_sdata, a_latch, a_clrn}, 0);
        bitq.delete();
        doneq.delete();
        tick();
        chk("no_latch_on_abort", latch_cyc - l0, 0);
        rst = 1'b0;
        chk("clrn_held_low", a_clrn, 0);
        tick();
        chk("clrn_restored", a_clrn, 1);
        run_one("after_reset", 64'hC3C3_3C3C_AAAA_5555, 2, 259);

        // Ignored start during SHIFT and during DONE
        r0 = rises; l0 = latch_cyc; b0 = busy_cyc; d0 = done_cnt;
        start_xfer(64'h0F1E_2D3C_4B5A_6978, 259, 1'b0);
        wait_until(last_t0 + 50);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        wait_done(d0 + 1, 320);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (300) tick();
        check_xfer("ignored_start", r0, l0, b0, d0, 2, 259);

        // Minimum divider instance
        sel = 1'b1;
        tick();
        run_one("div1_ones", 64'hFFFF_FFFF_FFFF_FFFF, 1, 130);
        run_one("div1_msb_lsb", 64'h8000_0000_0000_0001, 1, 130);
        sel = 1'b0;
        tick();

        chk("queues_drained", bitq.size() + doneq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
